// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified RAM between the CPU and the debug/loader port.
// Registered owner FSM with bounded hold time, optional debug lock and registered read return.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int MAX_HOLD = 8,
  parameter int DBG_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_rvalid,
  input  logic              dbg_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        owner
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CPU  = 2'd1;
  localparam logic [1:0] ST_DBG  = 2'd2;

  // Counter must reach MAX_HOLD-1, so it is sized from MAX_HOLD rather than fixed.
  localparam int              HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          hold_done_s;
  logic          owner_gnt_s;
  logic          other_req_s;
  logic [31:0]   cpu_rdata_q, dbg_rdata_q;
  logic          cpu_rvalid_q, dbg_rvalid_q;

  assign hold_done_s = (hold_q == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_gnt_s = 1'b0;
    other_req_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && dbg_req) begin
          state_d = (DBG_PRIO != 0) ? ST_DBG : ST_CPU;
        end else if (cpu_req) begin
          state_d = ST_CPU;
        end else if (dbg_req) begin
          state_d = ST_DBG;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CPU: begin
        owner_gnt_s = cpu_req;
        other_req_s = dbg_req;
        if (!cpu_req) begin
          state_d = dbg_req ? ST_DBG : ST_IDLE;
        end else if (dbg_req && hold_done_s) begin
          state_d = ST_DBG;
        end else begin
          state_d = ST_CPU;
        end
      end
      ST_DBG: begin
        owner_gnt_s = dbg_req;
        other_req_s = cpu_req;
        if (!dbg_req) begin
          state_d = cpu_req ? ST_CPU : ST_IDLE;
        end else if (cpu_req && hold_done_s && !dbg_lock) begin
          state_d = ST_CPU;
        end else begin
          state_d = ST_DBG;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Saturates so a long locked debug burst cannot wrap the counter.
    if ((state_d == state_q) && owner_gnt_s && other_req_s) begin
      hold_d = hold_done_s ? hold_q : hold_q + HW'(1);
    end else begin
      hold_d = '0;
    end
  end

  always_comb begin
    cpu_gnt   = (state_q == ST_CPU) && cpu_req && reset;
    dbg_gnt   = (state_q == ST_DBG) && dbg_req && reset;
    cpu_stall = cpu_req && !cpu_gnt;
    owner     = state_q;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end else if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
    end else begin
      mem_addr  = '0;
      mem_wdata = 32'h0000_0000;
      mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_rdata_q  <= 32'h0000_0000;
      cpu_rvalid_q <= 1'b0;
      dbg_rdata_q  <= 32'h0000_0000;
      dbg_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_gnt && !cpu_we;
      dbg_rvalid_q <= dbg_gnt && !dbg_we;
      if (cpu_gnt && !cpu_we) begin
        cpu_rdata_q <= mem_rdata;
      end else begin
        cpu_rdata_q <= cpu_rdata_q;
      end
      if (dbg_gnt && !dbg_we) begin
        dbg_rdata_q <= mem_rdata;
      end else begin
        dbg_rdata_q <= dbg_rdata_q;
      end
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model, read-data scoreboard, vector table and corner sequences.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_we;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  owner;

  logic        u2_cpu_gnt, u2_cpu_stall, u2_cpu_rvalid, u2_dbg_gnt, u2_dbg_rvalid, u2_mem_we;
  logic [31:0] u2_cpu_rdata, u2_dbg_rdata, u2_mem_addr, u2_mem_wdata;
  logic [1:0]  u2_owner;

  mem_port_arbiter #(.ADDR_W(32), .MAX_HOLD(8), .DBG_PRIO(0)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid), .dbg_lock(dbg_lock),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  // Second instance: debug priority and strict alternation.
  mem_port_arbiter #(.ADDR_W(32), .MAX_HOLD(1), .DBG_PRIO(1)) u_dut2 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(u2_cpu_gnt), .cpu_stall(u2_cpu_stall), .cpu_rdata(u2_cpu_rdata), .cpu_rvalid(u2_cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(u2_dbg_gnt), .dbg_rdata(u2_dbg_rdata), .dbg_rvalid(u2_dbg_rvalid), .dbg_lock(dbg_lock),
    .mem_addr(u2_mem_addr), .mem_we(u2_mem_we), .mem_wdata(u2_mem_wdata), .mem_rdata(32'hA5A5_A5A5),
    .owner(u2_owner)
  );

  logic [31:0] ram [0:63];
  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;

  logic [31:0] ref_mem [0:63];
  logic [31:0] cpu_q [$];
  logic [31:0] dbg_q [$];
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       c;
    logic       d;
    logic [1:0] own;
    logic       cg;
    logic       dg;
  } vec_t;
  vec_t tbl [0:10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every negative-edge sample also retires read returns against the scoreboard.
  task automatic neg();
    @(negedge clk);
    if (cpu_rvalid === 1'b1) begin
      if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'h0);
      else chk("cpu_rdata_sb", cpu_rdata, cpu_q.pop_front());
    end
    if (dbg_rvalid === 1'b1) begin
      if (dbg_q.size() == 0) chk("dbg_rvalid_unexpected", 32'(dbg_rvalid), 32'h0);
      else chk("dbg_rdata_sb", dbg_rdata, dbg_q.pop_front());
    end
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit is_dbg, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    bit done;
    done = 1'b0;
    if (is_dbg) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    for (int i = 0; i < 8 && !done; i++) begin
      neg();
      if ((is_dbg ? dbg_gnt : cpu_gnt) === 1'b1) begin
        done = 1'b1;
        if (we) ref_mem[addr[7:2]] = wd;
        else if (is_dbg) dbg_q.push_back(ref_mem[addr[7:2]]);
        else cpu_q.push_back(ref_mem[addr[7:2]]);
      end
      pos();
    end
    if (is_dbg) begin
      chk("dbg_gnt_timeout", 32'(done), 32'h1);
      dbg_req = 1'b0;
    end else begin
      chk("cpu_gnt_timeout", 32'(done), 32'h1);
      cpu_req = 1'b0;
    end
  endtask

  initial begin
    bit ec, e2d;
    reset = 1'b0; dbg_lock = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

    // Reset held with pending write requests
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h7C; cpu_wdata = 32'hFFFF_FFFF;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h78; dbg_wdata = 32'hEEEE_EEEE;
    for (int i = 0; i < 3; i++) begin
      pos(); neg();
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_owner", 32'(owner), 32'h0);
      chk("rst_rvalid", {30'b0, cpu_rvalid, dbg_rvalid}, 32'h0);
      chk("rst_cpu_rdata", cpu_rdata, 32'h0);
      chk("rst_dbg_rdata", dbg_rdata, 32'h0);
      chk("rst_gnt", {30'b0, cpu_gnt, dbg_gnt}, 32'h0);
      chk("rst_u2", {u2_owner, u2_mem_we, u2_cpu_rvalid, u2_dbg_rvalid}, 32'h0);
      chk("rst_u2_rdata", u2_cpu_rdata | u2_dbg_rdata, 32'h0);
    end
    pos();
    cpu_req = 1'b0; dbg_req = 1'b0; reset = 1'b1;
    neg();
    chk("post_rst_owner", 32'(owner), 32'h0);
    pos();

    // Locked debug burst while the CPU waits
    dbg_lock = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h0; dbg_wdata = 32'h1;
    neg();
    chk("t5_arb_owner", 32'(owner), 32'h0);
    pos();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 32'(i * 4); dbg_wdata = 32'(i + 1);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'hCAFE_0000;
      neg();
      chk("t5_dbg_gnt", 32'(dbg_gnt), 32'h1);
      chk("t5_cpu_gnt", 32'(cpu_gnt), 32'h0);
      chk("t5_mem_addr", mem_addr, 32'(i * 4));
      ref_mem[i] = 32'(i + 1);
      pos();
    end
    dbg_req = 1'b0; dbg_lock = 1'b0;
    neg();
    chk("t5_release_owner", 32'(owner), 32'h2);
    chk("t5_release_cpu_gnt", 32'(cpu_gnt), 32'h0);
    pos();
    neg();
    chk("t5_cpu_gnt_after", 32'(cpu_gnt), 32'h1);
    chk("t5_cpu_wdata", mem_wdata, 32'hCAFE_0000);
    ref_mem[32] = 32'hCAFE_0000;
    pos();
    cpu_req = 1'b0;
    for (int i = 0; i <= 32; i++) access(1'b1, 1'b0, 32'(i * 4), 32'h0);

    // Single CPU read latency
    access(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    neg(); pos(); neg(); pos();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
    neg();
    chk("t2_c1_owner", 32'(owner), 32'h0);
    chk("t2_c1_gnt", 32'(cpu_gnt), 32'h0);
    chk("t2_c1_stall", 32'(cpu_stall), 32'h1);
    pos();
    neg();
    chk("t2_c2_gnt", 32'(cpu_gnt), 32'h1);
    chk("t2_c2_stall", 32'(cpu_stall), 32'h0);
    chk("t2_c2_mem_addr", mem_addr, 32'h10);
    chk("t2_c2_mem_we", 32'(mem_we), 32'h0);
    cpu_q.push_back(ref_mem[4]);
    pos();
    cpu_req = 1'b0;
    neg();
    chk("t2_rvalid", 32'(cpu_rvalid), 32'h1);
    chk("t2_rdata", cpu_rdata, 32'hDEAD_BEEF);
    pos();
    neg();
    chk("t2_rvalid_pulse", 32'(cpu_rvalid), 32'h0);
    chk("t2_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);
    pos();

    // Arbitration vector table: {cpu_req, dbg_req, owner, cpu_gnt, dbg_gnt}
    tbl[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    cpu_we = 1'b0; cpu_addr = 32'h0; dbg_we = 1'b0; dbg_addr = 32'h4;
    for (int i = 0; i < 11; i++) begin
      cpu_req = tbl[i].c; dbg_req = tbl[i].d;
      neg();
      chk("vec_owner", 32'(owner), 32'(tbl[i].own));
      chk("vec_cpu_gnt", 32'(cpu_gnt), 32'(tbl[i].cg));
      chk("vec_dbg_gnt", 32'(dbg_gnt), 32'(tbl[i].dg));
      chk("vec_cpu_stall", 32'(cpu_stall), 32'(tbl[i].c & ~tbl[i].cg));
      if (tbl[i].cg) cpu_q.push_back(ref_mem[0]);
      if (tbl[i].dg) dbg_q.push_back(ref_mem[1]);
      pos();
    end

    // Continuous contention: 8/8 rotation on u_dut, alternation with debug first on u_dut2
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h1111_1111;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h14; dbg_wdata = 32'h2222_2222;
    neg();
    chk("t4_idle_gnt", {28'b0, cpu_gnt, dbg_gnt, u2_cpu_gnt, u2_dbg_gnt}, 32'h0);
    pos();
    for (int k = 0; k < 32; k++) begin
      neg();
      ec  = ((k / 8) % 2) == 0;
      e2d = (k % 2) == 0;
      chk("t4_cpu_gnt", 32'(cpu_gnt), 32'(ec));
      chk("t4_dbg_gnt", 32'(dbg_gnt), 32'(!ec));
      chk("t4_u2_dbg_gnt", 32'(u2_dbg_gnt), 32'(e2d));
      chk("t4_u2_cpu_gnt", 32'(u2_cpu_gnt), 32'(!e2d));
      chk("t4_u2_cpu_stall", 32'(u2_cpu_stall), 32'(e2d));
      chk("t4_u2_mem_addr", u2_mem_addr, e2d ? 32'h14 : 32'h10);
      chk("t4_u2_mem_wdata", u2_mem_wdata, e2d ? 32'h2222_2222 : 32'h1111_1111);
      if (ec) cpu_q.push_back(ref_mem[4]);
      else dbg_q.push_back(ref_mem[5]);
      pos();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    neg(); pos(); neg(); pos();

    // Reset during a granted debug write
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'h1234_5678;
    neg();
    chk("t6_arb_owner", 32'(owner), 32'h0);
    pos();
    neg();
    chk("t6_dbg_gnt", 32'(dbg_gnt), 32'h1);
    reset = 1'b0;
    #1;
    chk("t6_mem_we_forced", 32'(mem_we), 32'h0);
    pos();
    dbg_req = 1'b0;
    neg();
    chk("t6_owner", 32'(owner), 32'h0);
    chk("t6_dbg_rvalid", 32'(dbg_rvalid), 32'h0);
    pos();
    reset = 1'b1;
    access(1'b1, 1'b0, 32'h10, 32'h0);
    neg(); pos(); neg(); pos();
    chk("sb_drain", 32'(cpu_q.size() + dbg_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
